ddr_frame_reader: RTL and testbench
===================================

Name: ddr_frame_reader

Overview:
- Read-side consumer of the ping-pong bank controller's rd_bank/rd_load pair.
- On each rd_load, latches the bank and reads one full frame from DDR as a sequence of bounded read bursts. Pushes the returned data into the downstream Ethernet TX FIFO.
- Pulses frame_rd_done when the last word of the frame has been written to the FIFO, which lets the bank controller select the next read bank.

Parameters:
- ADDR_W, 25, DDR word address width; bank select is bits [ADDR_W-1:ADDR_W-2].
- DATA_W, 64, DDR user data width.
- FRAME_WORDS, 76800, DATA_W-wide words per frame (640x480x16bpp / 64).
- BURST_LEN, 64, maximum words per read command.
- FIFO_DEPTH, 1024, downstream FIFO depth in words.
- CNT_W, 11, width of fifo_wr_cnt; holds 0..FIFO_DEPTH.

Ports:
- phy_clk  in  1  sole clock.
- sys_rstn  in  1  asynchronous active-low reset.
- rd_bank  in  2  bank to read, sampled on rd_load.
- rd_load  in  1  one-cycle pulse that starts a frame read.
- ddr_rd_req  out  1  read command request.
- ddr_rd_addr  out  ADDR_W  command word address = {bank, offset}.
- ddr_rd_len  out  8  command length in words, 1..BURST_LEN.
- ddr_rd_ack  in  1  command accepted this cycle when ddr_rd_req=1.
- ddr_rd_data_valid  in  1  returned data beat valid.
- ddr_rd_data  in  DATA_W  returned data.
- fifo_wr_cnt  in  CNT_W  current fill of the downstream FIFO.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  DATA_W  FIFO write data.
- frame_rd_done  out  1  one-cycle pulse at frame completion.
- busy  out  1  high from rd_load acceptance through the frame_rd_done cycle.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, latched bank 0.
- IDLE:
  - On rd_load=1: latch bank <= rd_bank, offset <= 0, words_left <= FRAME_WORDS, busy <= 1, then go to WAIT_SPACE.
  - rd_load in any other state is ignored.
- WAIT_SPACE:
  - cur_len = min(BURST_LEN, words_left).
  - Proceed to REQ only when fifo_wr_cnt <= FIFO_DEPTH - BURST_LEN. Use the full-burst threshold even for the last, shorter burst.
- REQ:
  - ddr_rd_req=1, ddr_rd_addr={bank, offset[ADDR_W-3:0]}, ddr_rd_len=cur_len. All three are registered and held stable until the ack cycle.
  - On ddr_rd_ack: drop req the next cycle, beat_cnt <= 0, go to DATA.
- DATA:
  - Each ddr_rd_data_valid increments beat_cnt.
  - fifo_wr_en/fifo_wr_data are ddr_rd_data_valid/ddr_rd_data registered by one cycle, so latency is exactly 1.
  - On the beat where beat_cnt+1 == cur_len: offset += cur_len, words_left -= cur_len.
    - If the new words_left == 0, go to DONE.
    - Otherwise go to WAIT_SPACE.
- DONE:
  - frame_rd_done=1 for exactly one cycle; this coincides with the fifo_wr_en of the final word.
  - busy falls the following cycle; return to IDLE.
- Back-to-back commands: at most one command is outstanding. The next req cannot assert before the final beat of the previous burst has arrived.
- Stray data: ddr_rd_data_valid outside DATA is discarded and never written to the FIFO.
- Offset arithmetic: unsigned, width ADDR_W-2. It never wraps within a frame (FRAME_WORDS < 2^(ADDR_W-2)), so bank bits never change mid-frame.
- Gap cycles: ddr_rd_data_valid gaps inside a burst are legal and stall the beat count only.
- Reset mid-frame: returns immediately to reset values, and no frame_rd_done is issued.
- Next frame: the next rd_load after frame_rd_done starts cleanly with no residual state.

Decomposition:
- Package ddr_frame_pkg:
  - state encoding (IDLE, WAIT_SPACE, REQ, DATA, DONE);
  - bank-field position constants;
  - default FRAME_WORDS/BURST_LEN.
- Sub-module: none. The single FSM, counters and the 1-stage data register fit one module.
- Shared with the write side: the bank-bit constants in ddr_frame_pkg.

Test Plan:
- Basic frame, FRAME_WORDS=128, BURST_LEN=64, rd_bank=2'b10, rd_load, ack after 2 cycles, 64 valid beats per burst:
  - exactly two commands, at addresses 0x1000000 and 0x1000040, len=64 each;
  - 128 fifo_wr_en, each 1 cycle after its valid;
  - frame_rd_done high for one cycle, together with the 128th fifo_wr_en.
- Short tail, FRAME_WORDS=100:
  - commands len=64 at offset 0, then len=36 at offset 64;
  - done after 100 writes.
- Backpressure, fifo_wr_cnt=961 (> 1024-64) at start:
  - no ddr_rd_req while fifo_wr_cnt stays at 961;
  - drop fifo_wr_cnt to 960 → req asserts on the next cycle.
- Ack delay and data gaps, ack held off 10 cycles, valid toggled every other cycle:
  - addr/len stable throughout req;
  - beat count correct;
  - no extra or missing FIFO writes.
- Ignored events:
  - rd_load during DATA → no restart, bank unchanged;
  - valid pulses in IDLE → no fifo_wr_en.
- Reset mid-burst, assert sys_rstn=0 after 30 beats:
  - all outputs 0 immediately, no frame_rd_done;
  - subsequent rd_load with rd_bank=2'b01 reads from address 0x0800000.

Source files
------------

// File: rtl/ddr_frame_reader_pkg.sv
// rtl/ddr_frame_reader_pkg.sv - shared state encoding and bank-field constants for the frame reader
package ddr_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_SPACE = 3'd1,
        S_REQ        = 3'd2,
        S_DATA       = 3'd3,
        S_DONE       = 3'd4
    } rd_state_t;

    // The bank select occupies the top BANK_W bits of every DDR word address.
    localparam int BANK_W          = 2;
    localparam int DEF_ADDR_W      = 25;
    localparam int DEF_DATA_W      = 64;
    localparam int DEF_FRAME_WORDS = 76800;
    localparam int DEF_BURST_LEN   = 64;

    function automatic int bank_lsb(input int addr_w);
        return addr_w - BANK_W;
    endfunction

endpackage

// File: rtl/ddr_frame_reader_if.sv
// rtl/ddr_frame_reader_if.sv - DDR read command and read data channel between reader and memory controller
interface ddr_frame_reader_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 64
) ();

    logic              ddr_rd_req;
    logic [ADDR_W-1:0] ddr_rd_addr;
    logic [7:0]        ddr_rd_len;
    logic              ddr_rd_ack;
    logic              ddr_rd_data_valid;
    logic [DATA_W-1:0] ddr_rd_data;

    modport master (
        output ddr_rd_req,
        output ddr_rd_addr,
        output ddr_rd_len,
        input  ddr_rd_ack,
        input  ddr_rd_data_valid,
        input  ddr_rd_data
    );

    modport slave (
        input  ddr_rd_req,
        input  ddr_rd_addr,
        input  ddr_rd_len,
        output ddr_rd_ack,
        output ddr_rd_data_valid,
        output ddr_rd_data
    );

endinterface

// File: rtl/ddr_frame_reader.sv
// rtl/ddr_frame_reader.sv - reads one frame from a DDR bank in bounded bursts into the Ethernet TX FIFO
module ddr_frame_reader
    import ddr_frame_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int FIFO_DEPTH  = 1024,
    parameter int CNT_W       = 11
) (
    input  logic                phy_clk,
    input  logic                sys_rstn,
    input  logic [BANK_W-1:0]   rd_bank,
    input  logic                rd_load,
    ddr_frame_reader_if.master  ddr,
    input  logic [CNT_W-1:0]    fifo_wr_cnt,
    output logic                fifo_wr_en,
    output logic [DATA_W-1:0]   fifo_wr_data,
    output logic                frame_rd_done,
    output logic                busy
);

    localparam int OFF_W = ADDR_W - BANK_W;
    localparam int WL_W  = $clog2(FRAME_WORDS + 1);

    // A whole burst must fit even for the short tail burst, so the threshold never depends on cur_len.
    localparam logic [CNT_W-1:0] SPACE_LIMIT = CNT_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [WL_W-1:0]  BURST_WL    = WL_W'(BURST_LEN);

    rd_state_t         r_state;
    rd_state_t         w_next_state;

    logic [BANK_W-1:0] r_bank;
    logic [OFF_W-1:0]  r_offset;
    logic [WL_W-1:0]   r_words_left;
    logic [7:0]        r_beat_cnt;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_wr_data;

    logic [7:0]        w_cur_len;
    logic              w_space_ok;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_frame_end;

    assign w_cur_len   = (r_words_left < BURST_WL) ? 8'(r_words_left) : 8'(BURST_LEN);
    assign w_space_ok  = (fifo_wr_cnt <= SPACE_LIMIT);
    assign w_beat      = (r_state == S_DATA) && ddr.ddr_rd_data_valid;
    assign w_last_beat = w_beat && (({1'b0, r_beat_cnt} + 9'd1) == {1'b0, r_len});
    assign w_frame_end = (r_words_left == WL_W'(r_len));

    always_ff @(posedge phy_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:       if (rd_load)        w_next_state = S_WAIT_SPACE;
            S_WAIT_SPACE: if (w_space_ok)     w_next_state = S_REQ;
            S_REQ:        if (ddr.ddr_rd_ack) w_next_state = S_DATA;
            S_DATA:       if (w_last_beat)    w_next_state = w_frame_end ? S_DONE : S_WAIT_SPACE;
            S_DONE:                           w_next_state = S_IDLE;
            default:                          w_next_state = S_IDLE;
        endcase
    end

    // Done is decoded from the state entered on the final beat, so it lines up with that beat's FIFO write.
    always_comb begin
        frame_rd_done    = (r_state == S_DONE);
        busy             = (r_state != S_IDLE);
        ddr.ddr_rd_req   = r_req;
        ddr.ddr_rd_addr  = r_addr;
        ddr.ddr_rd_len   = r_len;
        fifo_wr_en       = r_wr_en;
        fifo_wr_data     = r_wr_data;
    end

    always_ff @(posedge phy_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_bank       <= '0;
            r_offset     <= '0;
            r_words_left <= '0;
            r_beat_cnt   <= '0;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_len        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
        end else begin
            r_wr_en <= w_beat;
            if (w_beat) begin
                r_wr_data <= ddr.ddr_rd_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (rd_load) begin
                        r_bank       <= rd_bank;
                        r_offset     <= '0;
                        r_words_left <= WL_W'(FRAME_WORDS);
                    end
                end
                S_WAIT_SPACE: begin
                    if (w_space_ok) begin
                        r_req  <= 1'b1;
                        r_addr <= {r_bank, r_offset};
                        r_len  <= w_cur_len;
                    end
                end
                S_REQ: begin
                    if (ddr.ddr_rd_ack) begin
                        r_req      <= 1'b0;
                        r_beat_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                    end
                    if (w_last_beat) begin
                        r_offset     <= r_offset + OFF_W'(r_len);
                        r_words_left <= r_words_left - WL_W'(r_len);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_frame_reader.sv
// tb/tb_ddr_frame_reader.sv - randomized DDR responder with a frame-level reference model for ddr_frame_reader
module tb_ddr_frame_reader;

    localparam int FW        = 100;
    localparam int BL        = 64;
    localparam int SPACE_MAX = 1024 - BL;

    logic        phy_clk = 1'b0;
    logic        sys_rstn;
    logic [1:0]  rd_bank;
    logic        rd_load;
    logic [10:0] fifo_wr_cnt;
    logic        fifo_wr_en;
    logic [63:0] fifo_wr_data;
    logic        frame_rd_done;
    logic        busy;

    ddr_frame_reader_if #(.ADDR_W(25), .DATA_W(64)) ddr_if ();

    ddr_frame_reader #(
        .ADDR_W(25), .DATA_W(64), .FRAME_WORDS(FW), .BURST_LEN(BL), .FIFO_DEPTH(1024), .CNT_W(11)
    ) dut (
        .phy_clk       (phy_clk),
        .sys_rstn      (sys_rstn),
        .rd_bank       (rd_bank),
        .rd_load       (rd_load),
        .ddr           (ddr_if),
        .fifo_wr_cnt   (fifo_wr_cnt),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .frame_rd_done (frame_rd_done),
        .busy          (busy)
    );

    always #5 phy_clk = ~phy_clk;

    int n_checks = 0;
    int n_err    = 0;

    // responder configuration
    int ack_delay_cfg = 2;
    int gap_mode      = 0;
    bit stray_en      = 1'b0;
    bit cnt_rand      = 1'b0;
    int cnt_fixed     = 0;

    // responder state
    int  sl_phase = 0;
    int  sl_delay = 0;
    int  sl_beats = 0;
    bit  sl_tog   = 1'b0;
    bit  sl_real  = 1'b0;

    // reference model state
    bit          m_busy = 1'b0;
    logic [1:0]  m_bank = '0;
    int          m_words = 0;
    int          m_cmd_idx = 0;
    bit          exp_en = 1'b0;
    logic [63:0] exp_data = '0;
    bit          exp_last = 1'b0;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [24:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;
    int          prev_cnt = 0;
    int          n_writes = 0;
    int          frames_done = 0;
    int          n_cmds = 0;
    logic [24:0] cmd_addr [0:15];
    logic [7:0]  cmd_len  [0:15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   64'(busy), 64'd0);
        check({tag, "_done"},   64'(frame_rd_done), 64'd0);
        check({tag, "_req"},    64'(ddr_if.ddr_rd_req), 64'd0);
        check({tag, "_addr"},   64'(ddr_if.ddr_rd_addr), 64'd0);
        check({tag, "_len"},    64'(ddr_if.ddr_rd_len), 64'd0);
        check({tag, "_wr_en"},  64'(fifo_wr_en), 64'd0);
        check({tag, "_wr_dat"}, fifo_wr_data, 64'd0);
    endtask

    // FIFO fill driver
    initial begin
        fifo_wr_cnt = '0;
        forever begin
            @(posedge phy_clk); #2;
            fifo_wr_cnt = cnt_rand ? 11'($urandom_range(900, 1024)) : 11'(cnt_fixed);
        end
    end

    // DDR responder: acks after a configurable delay, returns len beats with optional gaps, sprinkles stray valids
    initial begin
        ddr_if.ddr_rd_ack        = 1'b0;
        ddr_if.ddr_rd_data_valid = 1'b0;
        ddr_if.ddr_rd_data       = '0;
        forever begin
            @(posedge phy_clk); #1;
            ddr_if.ddr_rd_ack        = 1'b0;
            ddr_if.ddr_rd_data_valid = 1'b0;
            sl_real                  = 1'b0;
            if (!sys_rstn) begin
                sl_phase = 0;
                continue;
            end
            if (sl_phase != 2) begin
                if (ddr_if.ddr_rd_req) begin
                    if (sl_phase == 0) begin
                        sl_delay = (ack_delay_cfg < 0) ? int'($urandom_range(0, 5)) : ack_delay_cfg;
                        sl_phase = 1;
                    end
                    if (sl_delay == 0) begin
                        ddr_if.ddr_rd_ack = 1'b1;
                        sl_beats = int'(ddr_if.ddr_rd_len);
                        sl_tog   = 1'b1;
                        sl_phase = (sl_beats == 0) ? 0 : 2;
                    end else begin
                        sl_delay--;
                    end
                end
                if (stray_en && $urandom_range(0, 3) == 0) begin
                    ddr_if.ddr_rd_data_valid = 1'b1;
                    ddr_if.ddr_rd_data       = {$urandom, $urandom};
                end
            end else begin
                bit give;
                give = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? sl_tog : ($urandom_range(0, 2) != 0);
                sl_tog = !sl_tog;
                if (give) begin
                    ddr_if.ddr_rd_data_valid = 1'b1;
                    ddr_if.ddr_rd_data       = {$urandom, $urandom};
                    sl_real                  = 1'b1;
                    sl_beats--;
                    if (sl_beats == 0) sl_phase = 0;
                end
            end
        end
    end

    // Compare process: frame-level model of commands, FIFO writes, done and busy
    initial begin
        forever begin
            @(negedge phy_clk);
            if (!sys_rstn) begin
                m_busy = 0; m_words = 0; m_cmd_idx = 0; exp_en = 0; exp_last = 0;
                prev_req = 0; prev_ack = 0; prev_cnt = 0;
                continue;
            end
            check("fifo_wr_en", 64'(fifo_wr_en), 64'(exp_en));
            if (exp_en) check("fifo_wr_data", fifo_wr_data, exp_data);
            check("frame_rd_done", 64'(frame_rd_done), 64'(exp_last));
            check("busy", 64'(busy), 64'(m_busy));

            if (ddr_if.ddr_rd_req) begin
                if (sl_phase == 2 && !ddr_if.ddr_rd_ack) fail("req_while_burst_outstanding");
                if (prev_ack) fail("req_held_after_ack");
                if (!prev_req && prev_cnt > SPACE_MAX) fail("req_without_fifo_space");
                if (prev_req) begin
                    check("addr_stable", 64'(ddr_if.ddr_rd_addr), 64'(prev_addr));
                    check("len_stable", 64'(ddr_if.ddr_rd_len), 64'(prev_len));
                end
                if (ddr_if.ddr_rd_ack) begin
                    int off;
                    int len;
                    off = BL * m_cmd_idx;
                    len = (FW - off < BL) ? FW - off : BL;
                    if (off >= FW) begin
                        fail("extra_command");
                    end else begin
                        check("cmd_addr", 64'(ddr_if.ddr_rd_addr), 64'({m_bank, 23'(off)}));
                        check("cmd_len", 64'(ddr_if.ddr_rd_len), 64'(len));
                    end
                    if (n_cmds < 16) begin
                        cmd_addr[n_cmds] = ddr_if.ddr_rd_addr;
                        cmd_len[n_cmds]  = ddr_if.ddr_rd_len;
                    end
                    n_cmds++;
                    m_cmd_idx++;
                end
            end else if (prev_req && !prev_ack) begin
                fail("req_dropped_before_ack");
            end

            if (fifo_wr_en) n_writes++;
            if (frame_rd_done) frames_done++;

            begin
                bit nb;
                nb = m_busy ? !exp_last : rd_load;
                if (!m_busy && rd_load) begin
                    m_bank = rd_bank; m_words = 0; m_cmd_idx = 0; n_cmds = 0; n_writes = 0;
                end
                exp_en   = ddr_if.ddr_rd_data_valid && sl_real;
                exp_data = ddr_if.ddr_rd_data;
                exp_last = 1'b0;
                if (exp_en) begin
                    m_words++;
                    if (m_words == FW) exp_last = 1'b1;
                end
                m_busy = nb;
            end
            prev_req  = ddr_if.ddr_rd_req;
            prev_ack  = ddr_if.ddr_rd_ack && ddr_if.ddr_rd_req;
            prev_addr = ddr_if.ddr_rd_addr;
            prev_len  = ddr_if.ddr_rd_len;
            prev_cnt  = int'(fifo_wr_cnt);
        end
    end

    task automatic pulse_load(input logic [1:0] b);
        @(posedge phy_clk); #1;
        rd_bank = b;
        rd_load = 1'b1;
        @(posedge phy_clk); #1;
        rd_load = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int start;
        bit seen;
        start = frames_done;
        seen  = 1'b0;
        for (int t = 0; t < 3000 && !seen; t++) begin
            @(negedge phy_clk);
            if (frames_done != start) seen = 1'b1;
        end
        if (!seen) fail({tag, "_timeout"});
        @(negedge phy_clk);
    endtask

    initial begin
        sys_rstn = 1'b0;
        rd_load  = 1'b0;
        rd_bank  = '0;
        repeat (3) @(posedge phy_clk);
        #1;
        check_all_zero("reset");
        @(posedge phy_clk); #2;
        sys_rstn = 1'b1;

        // stray valids while idle
        stray_en = 1'b1;
        repeat (12) @(posedge phy_clk);

        // basic frame with a short tail burst
        ack_delay_cfg = 2; gap_mode = 0;
        pulse_load(2'b10);
        wait_done("frame_a");
        check("a_ncmds", 64'(n_cmds), 64'd2);
        check("a_addr0", 64'(cmd_addr[0]), 64'h1000000);
        check("a_len0", 64'(cmd_len[0]), 64'd64);
        check("a_addr1", 64'(cmd_addr[1]), 64'h1000040);
        check("a_len1", 64'(cmd_len[1]), 64'd36);
        check("a_writes", 64'(n_writes), 64'd100);

        // backpressure, long ack delay, alternating data gaps
        cnt_fixed = 961; ack_delay_cfg = 10; gap_mode = 1;
        repeat (2) @(posedge phy_clk);
        pulse_load(2'b01);
        for (int i = 0; i < 20; i++) begin
            @(negedge phy_clk);
            check("bp_no_req", 64'(ddr_if.ddr_rd_req), 64'd0);
        end
        @(posedge phy_clk); #1;
        cnt_fixed = 960;
        @(posedge phy_clk);
        @(negedge phy_clk);
        check("bp_req_on_space", 64'(ddr_if.ddr_rd_req), 64'd1);
        wait_done("frame_b");
        check("b_writes", 64'(n_writes), 64'd100);
        cnt_fixed = 0;

        // rd_load during DATA must be ignored
        ack_delay_cfg = -1; gap_mode = 2;
        pulse_load(2'b11);
        for (int t = 0; t < 200 && sl_phase != 2; t++) @(negedge phy_clk);
        pulse_load(2'b00);
        wait_done("frame_c");
        check("c_ncmds", 64'(n_cmds), 64'd2);
        check("c_bank0", 64'(cmd_addr[0][24:23]), 64'd3);
        check("c_bank1", 64'(cmd_addr[1][24:23]), 64'd3);

        // reset after 30 beats, then a clean frame from bank 1
        begin
            int fd;
            ack_delay_cfg = 1; gap_mode = 0;
            pulse_load(2'b10);
            for (int t = 0; t < 500 && n_writes < 30; t++) @(negedge phy_clk);
            check("rst_reached_30", 64'(n_writes >= 30), 64'd1);
            fd = frames_done;
            @(posedge phy_clk); #3;
            sys_rstn = 1'b0;
            #1;
            check_all_zero("midreset");
            repeat (3) @(negedge phy_clk);
            @(posedge phy_clk); #2;
            sys_rstn = 1'b1;
            repeat (4) @(negedge phy_clk);
            check("no_done_after_reset", 64'(frames_done), 64'(fd));
            pulse_load(2'b01);
            wait_done("frame_d");
            check("d_addr0", 64'(cmd_addr[0]), 64'h0800000);
            check("d_writes", 64'(n_writes), 64'd100);
        end

        // randomized frames with random FIFO fill and gaps
        cnt_rand = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ack_delay_cfg = -1;
            gap_mode      = int'($urandom_range(0, 2));
            pulse_load(2'($urandom_range(0, 3)));
            wait_done("frame_rand");
            check("rand_writes", 64'(n_writes), 64'd100);
            check("rand_ncmds", 64'(n_cmds), 64'd2);
        end
        cnt_rand = 1'b0;
        repeat (5) @(posedge phy_clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $finish;
    end

endmodule
